// File: rtl/keypad_pkg.sv
// keypad_scanner shared types and constants.
// Imported by the scanner top and its testbench-facing ports.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } cand_e;

  function automatic logic [2:0] ones4(
    input logic [3:0] v
  );
    return 3'(v[0]) + 3'(v[1])
         + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Generic-width two-flop synchronizer.
// Async active-low reset clears both stages.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with frame debounce
// and a single-entry valid/ready event output.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ROWS-1:0]  row_n_i,
  output logic [COLS-1:0]  col_n_o,
  output logic [KEY_W-1:0] key_code_o,
  output logic             key_valid_o,
  input  logic             key_ready_i,
  output logic             key_held_o,
  output logic             overrun_o
);

  localparam int DW = 17;
  localparam logic [DW-1:0] DIV_MAX =
    DW'(SCAN_DIV - 1);
  localparam logic [3:0] DS =
    4'(DEBOUNCE_SCANS);

  logic [ROWS-1:0]  row_s;
  logic [DW-1:0]    div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [COLS-1:0]  col_n_q, col_n_d;
  logic             tc, frame_end;

  logic [1:0]       hits_q, hits_d;
  logic [KEY_W-1:0] acc_q, acc_d;
  logic [ROWS-1:0]  row_low;
  logic [2:0]       slot_n, sum;
  logic [1:0]       row_idx;
  logic [KEY_W-1:0] slot_code;
  logic [KEY_W-1:0] ccode;
  cand_e            kind;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] cur_q, cur_d;
  logic             emit;
  logic             same;

  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             ovr_q, ovr_d;

  sync_2ff #(.W(ROWS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (row_n_i),
    .q_o     (row_s)
  );

  assign tc        = (div_q == DIV_MAX);
  assign frame_end = tc && (col_q == 2'd3);

  always_comb begin
    div_d   = tc ? '0 : div_q + DW'(1);
    col_d   = tc ? col_q + 2'd1 : col_q;
    col_n_d = ~(COLS'(1) << col_d);
  end

  // Fold this slot's sample into the running frame tally.
  always_comb begin
    row_low = ~row_s;
    slot_n  = ones4(row_low);
    row_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_low[r]) row_idx = 2'(r);
    end
    slot_code = {row_idx, col_q};
    sum       = 3'(hits_q) + slot_n;
    ccode     = (hits_q == 2'd1) ? acc_q
                                 : slot_code;
    unique case (1'b1)
      (sum == 3'd0): kind = NONE;
      (sum == 3'd1): kind = SINGLE;
      default:       kind = MULTI;
    endcase
    hits_d = hits_q;
    acc_d  = acc_q;
    if (frame_end) begin
      hits_d = '0;
    end else if (tc) begin
      hits_d = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      acc_d  = ccode;
    end
  end

  assign same = (kind == SINGLE) &&
                (ccode == cur_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    emit    = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (kind == SINGLE) begin
            cur_d = ccode;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = HELD;
              emit    = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (same) begin
            if (cnt_q + 4'd1 == DS) begin
              state_d = HELD;
              cnt_d   = '0;
              emit    = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (kind == SINGLE) begin
            cur_d = ccode;
            cnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (!same) begin
            if (DEBOUNCE_SCANS == 1 &&
                kind == NONE) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = (kind == NONE) ? 4'd1
                                       : 4'd0;
            end
          end
        end
        RELEASE: begin
          if (kind == NONE) begin
            if (cnt_q + 4'd1 == DS) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (same) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // One-deep output slot; a busy slot drops the new event.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    held_d  = (state_d == HELD) ||
              (state_d == RELEASE);
    if (valid_q && key_ready_i) valid_d = 1'b0;
    if (emit) begin
      if (!valid_q || key_ready_i) begin
        code_d  = cur_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      col_q   <= '0;
      col_n_q <= 4'b1110;
      hits_q  <= '0;
      acc_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      col_n_q <= col_n_d;
      hits_q  <= hits_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      ovr_q   <= ovr_d;
    end
  end

  assign col_n_o     = col_n_q;
  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_held_o  = held_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// keypad_scanner bench: keypad emulation, frame-level
// reference model and a queue scoreboard.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int exp_ovr = 0;
  int ovr_seen = 0;
  int unsigned ecnt;
  logic [3:0] q[$];

  int run_n = 0;
  int run_k = 0;
  int none_n = 0;
  bit held = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .row_n_i     (row_n),
    .col_n_o     (col_n),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_ready_i (key_ready),
    .key_held_o  (key_held),
    .overrun_o   (overrun)
  );

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ecol;
    if (reset_n) begin
      ecol = ~(4'b0001 << ((ecnt / SD) % 4));
      chk("col_n", col_n, ecol);
      chk("valid", key_valid, q.size() != 0);
      if (key_valid && q.size() != 0) begin
        chk("code", key_code, q[0]);
        if (key_ready) void'(q.pop_front());
      end
      if (overrun) ovr_seen++;
    end
  end

  task automatic model_frame(input logic [15:0] k);
    int n;
    int kc;
    bit emit;
    bit drop;
    n = $countones(k);
    kc = 0;
    emit = 0;
    drop = 0;
    for (int b = 0; b < 16; b++) if (k[b]) kc = b;
    if (!held) begin
      if (n == 1) begin
        if (run_n > 0 && run_k == kc) run_n++;
        else begin
          run_k = kc;
          run_n = 1;
        end
      end else begin
        run_n = 0;
      end
      if (run_n == DS) begin
        held = 1;
        run_n = 0;
        none_n = 0;
        emit = 1;
      end
    end else begin
      none_n = (n == 0) ? none_n + 1 : 0;
      if (none_n == DS) begin
        held = 0;
        none_n = 0;
      end
    end
    if (emit) begin
      if (q.size() != 0) begin
        drop = 1;
        exp_ovr++;
      end else begin
        q.push_back(4'(kc));
      end
    end
    chk("overrun", overrun, drop);
    chk("held", key_held, held);
  endtask

  // rmode: 0 ready low, 1 random, 2 ready high.
  task automatic frame(input logic [15:0] k,
                       input int rmode,
                       input int ncyc = 16);
    keys = k;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      if (i == 16) model_frame(k);
      case (rmode)
        0:       key_ready = 1'b0;
        2:       key_ready = 1'b1;
        default: key_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    keys = '0;
    key_ready = 1'b0;
    #1;
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_code", key_code, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovr", overrun, 0);
    q.delete();
    held = 0;
    run_n = 0;
    none_n = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int ob;
    int a;
    int b;
    int len;
    logic [15:0] k;

    do_reset();
    repeat (2) frame('0, 2);

    // steady press of key 6, consumer stalled
    repeat (5) frame(16'(1) << 6, 0);
    chk("press_code", key_code, 6);
    chk("press_valid", key_valid, 1);
    repeat (3) frame('0, 2);
    chk("rel_valid", key_valid, 0);

    // single-frame bounce
    frame(16'(1) << 6, 1);
    repeat (3) frame('0, 1);

    // keys 0 and 5 together
    repeat (4) frame(16'h0021, 1);
    repeat (2) frame('0, 1);

    // backpressure: second press dropped
    ob = ovr_seen;
    repeat (3) frame(16'(1) << 3, 0);
    repeat (2) frame('0, 0);
    repeat (3) frame(16'(1) << 9, 0);
    chk("bp_code", key_code, 3);
    chk("bp_valid", key_valid, 1);
    chk("bp_ovr", ovr_seen - ob, 1);
    frame('0, 2);

    // reset while debouncing
    do_reset();
    frame(16'(1) << 6, 1);
    frame(16'(1) << 6, 1, 8);
    do_reset();
    repeat (3) frame(16'(1) << 6, 2);
    repeat (2) frame('0, 2);

    // reset with an unconsumed event
    do_reset();
    repeat (2) frame(16'(1) << 6, 0);
    chk("pend_valid", key_valid, 1);
    frame(16'(1) << 6, 0, 5);
    do_reset();
    repeat (3) frame(16'(1) << 6, 2);
    repeat (2) frame('0, 2);

    // randomized key traffic
    for (int s = 0; s < 40; s++) begin
      a = $urandom_range(0, 99);
      if (a < 45) begin
        k = '0;
      end else if (a < 85) begin
        case ($urandom_range(0, 3))
          0:       k = 16'(1) << 6;
          1:       k = 16'(1) << 9;
          2:       k = 16'(1) << 3;
          default: k = 16'(1) << 12;
        endcase
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        k = (16'(1) << a) | (16'(1) << b);
      end
      len = $urandom_range(1, 3);
      repeat (len) frame(k, 1);
    end
    repeat (3) frame('0, 2);

    chk("ovr_count", ovr_seen, exp_ovr);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
